// File: rtl/fifo_stream_pkg.sv
// Shared defaults and legal-configuration helpers for the FIFO read-side stream stage.
package fifo_stream_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int PKT_LEN_DEF = 16;
  localparam int PKT_CNT_W   = 16;
  localparam int RD_LAT_MIN  = 0;
  localparam int RD_LAT_MAX  = 1;

  function automatic bit rd_latency_ok(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/stream_buf.sv
// Small circular register FIFO that holds bytes between FIFO capture and stream handoff.
module stream_buf #(
  parameter int DEPTH  = 3,
  parameter int DATA_W = 8,
  parameter int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [OCC_W-1:0]  occ,
  output logic [DATA_W-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL     = OCC_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              do_pop;
  logic              do_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop && (occ != '0);
  assign do_push = push && ((occ != FULL) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      occ <= occ + OCC_W'(1);
      else if (!do_push && do_pop) occ <= occ - OCC_W'(1);
    end
  end

  // Storage carries no reset; only the pointers and occupancy qualify it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the async FIFO read port into a valid/ready byte stream, framed into
// fixed-length packets with a wrapping count of completed packets.
module fifo_rd_stream
  import fifo_stream_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LATENCY = 1,
  parameter int PKT_LEN    = PKT_LEN_DEF,
  parameter int BUF_DEPTH  = RD_LATENCY + 2
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [DATA_W-1:0]    fifo_rd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_last,
  output logic [PKT_CNT_W-1:0] pkt_count
);

  localparam int OCC_W  = $clog2(BUF_DEPTH + 1);
  localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);
  localparam logic [OCC_W:0]    CREDITS   = (OCC_W + 1)'(BUF_DEPTH);

  if (!rd_latency_ok(RD_LATENCY) || (PKT_LEN < 1)) begin : g_bad_cfg
    $error("fifo_rd_stream: RD_LATENCY must be 0 or 1 and PKT_LEN must be at least 1");
  end

  logic [OCC_W-1:0]  occ;
  logic [DATA_W-1:0] head;
  logic              inflight;
  logic              push;
  logic              xfer;
  logic [BEAT_W-1:0] beat_cnt;

  // Credits cover both buffered bytes and pops whose data is still in the FIFO
  // read pipeline; out_ready is deliberately kept out of this path.
  assign fifo_rd_en = !rd_rst && !fifo_empty &&
                      (({1'b0, occ} + (OCC_W + 1)'(inflight)) < CREDITS);

  if (RD_LATENCY == 0) begin : g_lat0
    assign inflight = 1'b0;
    assign push     = fifo_rd_en;
  end else begin : g_lat1
    // p1: pop issued last cycle, data valid on fifo_rd_data now
    always_ff @(posedge rd_clk) begin
      if (rd_rst) inflight <= 1'b0;
      else        inflight <= fifo_rd_en;
    end
    assign push = inflight;
  end

  stream_buf #(
    .DEPTH  (BUF_DEPTH),
    .DATA_W (DATA_W),
    .OCC_W  (OCC_W)
  ) u_buf (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .push      (push),
    .push_data (fifo_rd_data),
    .pop       (xfer),
    .occ       (occ),
    .head      (head)
  );

  assign out_valid = (occ != '0);
  assign xfer      = out_valid && out_ready;
  assign out_data  = out_valid ? head : '0;
  assign out_last  = out_valid && (beat_cnt == LAST_BEAT);

  // Framing state only moves on transfers, so a FIFO underrun leaves it parked.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      beat_cnt  <= '0;
      pkt_count <= '0;
    end else if (xfer) begin
      beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BEAT_W'(1);
      if (out_last) pkt_count <= pkt_count + PKT_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a RD_LATENCY=1/PKT_LEN=16 instance for directed
// sequences and a RD_LATENCY=0/PKT_LEN=1 instance for a long random sweep.
module tb_fifo_rd_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_rd_en, a_valid, a_ready, a_last;
  logic        a_fempty = 1'b1;
  logic [7:0]  a_fdata = 8'h00;
  logic [7:0]  a_data;
  logic [15:0] a_pkt;
  logic        b_rst, b_rd_en, b_valid, b_ready, b_last;
  logic        b_fempty = 1'b1;
  logic [7:0]  b_fdata = 8'h00;
  logic [7:0]  b_data;
  logic [15:0] b_pkt;

  fifo_rd_stream #(.DATA_W(8), .RD_LATENCY(1), .PKT_LEN(16)) dut_a (
    .rd_clk(clk), .rd_rst(a_rst), .fifo_empty(a_fempty), .fifo_rd_en(a_rd_en),
    .fifo_rd_data(a_fdata), .out_valid(a_valid), .out_ready(a_ready),
    .out_data(a_data), .out_last(a_last), .pkt_count(a_pkt));

  fifo_rd_stream #(.DATA_W(8), .RD_LATENCY(0), .PKT_LEN(1)) dut_b (
    .rd_clk(clk), .rd_rst(b_rst), .fifo_empty(b_fempty), .fifo_rd_en(b_rd_en),
    .fifo_rd_data(b_fdata), .out_valid(b_valid), .out_ready(b_ready),
    .out_data(b_data), .out_last(b_last), .pkt_count(b_pkt));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
  endtask

  // FIFO contents, and every byte still owed to the stream in order
  logic [7:0] qa[$], exp_a[$], a_lastlog[$];
  logic [7:0] qb[$], exp_b[$];

  int   a_cnt = 0, a_pkt_m = 0, a_out = 0, a_xfers = 0, a_pops = 0, a_cyc = 0;
  int   a_first_x = -1, a_last_x = -1;
  bit   a_in_rst = 0, a_hold = 0, a_en_s = 0;
  logic [7:0] a_hold_d;
  logic a_hold_l;
  int   b_pkt_m = 0, b_out = 0, b_xfers = 0, b_last_cnt = 0, b_pushed = 0;
  bit   b_in_rst = 0, b_hold = 0, b_en_s = 0;
  logic [7:0] b_hold_d;

  // Monitor/scoreboard for instance A (outputs sampled mid-cycle)
  always @(negedge clk) begin
    logic xf;
    logic [7:0] e;
    a_cyc++;
    xf = a_valid && a_ready;
    if (a_rst) chk("a_en_in_rst", a_rd_en, 0);
    if (a_fempty) chk("a_en_when_empty", a_rd_en, 0);
    if (a_in_rst) begin
      chk("a_rst_valid", a_valid, 0);
      chk("a_rst_data", a_data, 0);
      chk("a_rst_last", a_last, 0);
    end
    if (a_hold) begin
      chk("a_hold_valid", a_valid, 1);
      chk("a_hold_data", a_data, a_hold_d);
      chk("a_hold_last", a_last, a_hold_l);
    end
    chk("a_last", a_last, a_valid && (a_cnt == 15));
    chk("a_pkt", a_pkt, a_pkt_m);
    if (xf) begin
      if (exp_a.size() == 0) chk("a_extra_byte", exp_a.size(), 1);
      else begin
        e = exp_a.pop_front();
        chk("a_data", a_data, e);
      end
      if (a_last) a_lastlog.push_back(a_data);
      if (a_cnt == 15) a_pkt_m = (a_pkt_m + 1) % 65536;
      a_cnt = (a_cnt + 1) % 16;
      a_xfers++;
      if (a_first_x < 0) a_first_x = a_cyc;
      a_last_x = a_cyc;
    end
    if (a_rd_en) a_pops++;
    a_out += int'(a_rd_en) - int'(xf);
    chk("a_bytes_owed_le_3", a_out <= 3, 1);
    a_hold   = a_valid && !a_ready;
    a_hold_d = a_data;
    a_hold_l = a_last;
    a_en_s   = a_rd_en;
    if (a_rst) begin
      a_cnt = 0; a_pkt_m = 0; a_out = 0; a_hold = 0;
      exp_a = qa;
    end
    a_in_rst = a_rst;
  end

  // Monitor/scoreboard for instance B: every byte is a whole packet
  always @(negedge clk) begin
    logic xf;
    logic [7:0] e;
    xf = b_valid && b_ready;
    if (b_rst) chk("b_en_in_rst", b_rd_en, 0);
    if (b_fempty) chk("b_en_when_empty", b_rd_en, 0);
    if (b_in_rst) begin
      chk("b_rst_valid", b_valid, 0);
      chk("b_rst_data", b_data, 0);
    end
    if (b_hold) begin
      chk("b_hold_valid", b_valid, 1);
      chk("b_hold_data", b_data, b_hold_d);
    end
    chk("b_last", b_last, b_valid);
    chk("b_pkt", b_pkt, b_pkt_m);
    if (xf) begin
      if (exp_b.size() == 0) chk("b_extra_byte", exp_b.size(), 1);
      else begin
        e = exp_b.pop_front();
        chk("b_data", b_data, e);
      end
      if (b_last) b_last_cnt++;
      b_pkt_m = (b_pkt_m + 1) % 65536;
      b_xfers++;
    end
    b_out += int'(b_rd_en) - int'(xf);
    chk("b_bytes_owed_le_2", b_out <= 2, 1);
    b_hold   = b_valid && !b_ready;
    b_hold_d = b_data;
    b_en_s   = b_rd_en;
    if (b_rst) begin
      b_pkt_m = 0; b_out = 0; b_hold = 0;
      exp_b = qb;
    end
    b_in_rst = b_rst;
  end

  // FIFO read-port models: A registers data one cycle after the pop, B is show-ahead
  always @(posedge clk) begin
    #1;
    if (a_en_s && qa.size() > 0) a_fdata = qa.pop_front();
    a_fempty = (qa.size() == 0);
    if (b_en_s && qb.size() > 0) void'(qb.pop_front());
    b_fempty = (qb.size() == 0);
    b_fdata  = b_fempty ? 8'h00 : qb[0];
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_a(input logic [7:0] v);
    qa.push_back(v);
    exp_a.push_back(v);
  endtask

  task automatic push_b(input logic [7:0] v);
    qb.push_back(v);
    exp_b.push_back(v);
  endtask

  task automatic reset_a();
    a_rst = 1'b1;
    step();
    a_rst = 1'b0;
    a_xfers = 0;
    a_lastlog.delete();
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic        valid;
    logic [7:0]  data;
    logic        last;
    logic [15:0] pkt;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int x0;
    vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 16'd0};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 16'd0};

    a_rst = 1'b1; a_ready = 1'b1;
    b_rst = 1'b1; b_ready = 1'b0;
    for (int i = 0; i < 32; i++) push_a(8'(i));
    step();

    // Reset held with a non-empty FIFO, then release and first two bytes
    for (int i = 0; i < 7; i++) begin
      a_rst = vecs[i].rst;
      @(negedge clk);
      chk($sformatf("vec%0d_rd_en", i), a_rd_en, vecs[i].en);
      chk($sformatf("vec%0d_valid", i), a_valid, vecs[i].valid);
      chk($sformatf("vec%0d_data", i), a_data, vecs[i].data);
      chk($sformatf("vec%0d_last", i), a_last, vecs[i].last);
      chk($sformatf("vec%0d_pkt", i), a_pkt, vecs[i].pkt);
      step();
    end

    // Full-rate streaming of 32 bytes
    for (int i = 0; i < 100 && a_xfers < 32; i++) step();
    chk("stream_count", a_xfers, 32);
    chk("stream_back_to_back", a_last_x - a_first_x, 31);
    chk("stream_pkt", a_pkt, 2);
    chk("stream_last_count", a_lastlog.size(), 2);
    if (a_lastlog.size() == 2) begin
      chk("stream_last0", a_lastlog[0], 8'h0F);
      chk("stream_last1", a_lastlog[1], 8'h1F);
    end

    // Backpressure mid-stream
    for (int i = 0; i < 32; i++) push_a(8'(8'h20 + i));
    for (int i = 0; i < 100 && a_xfers < 40; i++) step();
    chk("bp_reached", a_xfers, 40);
    a_ready = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("bp_head", a_data, 8'h28);
    chk("bp_bytes_buffered", a_out, 3);
    chk("bp_rd_en_low", a_rd_en, 0);
    a_ready = 1'b1;
    x0 = a_xfers;
    @(negedge clk);
    chk("bp_resume_valid", a_valid, 1);
    #1;
    chk("bp_resume_xfer", a_xfers, x0 + 1);
    step();
    for (int i = 0; i < 100 && a_xfers < 64; i++) step();
    chk("bp_total", a_xfers, 64);
    chk("bp_pkt", a_pkt, 4);
    chk("bp_nothing_owed", exp_a.size(), 0);

    // FIFO underrun in the middle of a packet
    reset_a();
    for (int i = 0; i < 5; i++) push_a(8'(8'h40 + i));
    for (int i = 0; i < 50 && a_xfers < 5; i++) step();
    repeat (3) step();
    @(negedge clk);
    chk("underrun_valid_drop", a_valid, 0);
    step();
    repeat (20) step();
    for (int i = 5; i < 16; i++) push_a(8'(8'h40 + i));
    for (int i = 0; i < 60 && a_xfers < 16; i++) step();
    chk("underrun_total", a_xfers, 16);
    chk("underrun_last_count", a_lastlog.size(), 1);
    if (a_lastlog.size() == 1) chk("underrun_last_byte", a_lastlog[0], 8'h4F);
    chk("underrun_pkt", a_pkt, 1);

    // Reset pulse in the middle of a packet, FIFO reset alongside
    reset_a();
    for (int i = 0; i < 20; i++) push_a(8'(8'h60 + i));
    for (int i = 0; i < 50 && a_xfers < 7; i++) step();
    chk("midrst_reached", a_xfers, 7);
    a_ready = 1'b0;
    a_rst = 1'b1;
    qa.delete();
    step();
    a_rst = 1'b0;
    a_ready = 1'b1;
    a_xfers = 0;
    a_lastlog.delete();
    @(negedge clk);
    chk("midrst_valid", a_valid, 0);
    chk("midrst_pkt", a_pkt, 0);
    step();
    for (int i = 0; i < 16; i++) push_a(8'(8'hA0 + i));
    for (int i = 0; i < 60 && a_xfers < 16; i++) step();
    chk("midrst_total", a_xfers, 16);
    chk("midrst_last_count", a_lastlog.size(), 1);
    if (a_lastlog.size() == 1) chk("midrst_last_byte", a_lastlog[0], 8'hAF);
    chk("midrst_pkt_after", a_pkt, 1);
    chk("midrst_nothing_owed", exp_a.size(), 0);

    // Zero-latency, single-byte-packet sweep with random backpressure
    b_rst = 1'b0;
    for (int i = 0; i < 85000 && b_xfers < 70000; i++) begin
      while (b_pushed < 70000 && qb.size() < 4) begin
        push_b(8'($urandom));
        b_pushed++;
      end
      b_ready = ($urandom_range(0, 15) != 0);
      step();
    end
    chk("sweep_total", b_xfers, 70000);
    chk("sweep_pkt_wrap", b_pkt, 4464);
    chk("sweep_last_every_byte", b_last_cnt, 70000);
    chk("sweep_nothing_owed", exp_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
